// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor sequencer driving one full-subtractor cell, LSB first
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_n;
  logic [CW-1:0] cnt;
  logic br, x, y, d, bn, last;
  always_comb begin
    x       = a_sr[0];
    y       = b_sr[0];
    d       = x ^ y ^ br;
    bn      = (~x & y) | (~(x ^ y) & br);
    res_n   = {d, res_sr[WIDTH-1:1]};
    last    = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
    busy    = state != IDLE;
    done    = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      res_sr <= res_n;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= bn;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff <= res_n;
        bout <= bn;
        zero <= res_n == '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=16
module tb_serial_sub_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start8 = 0, bin8 = 0, busy8, done8, bout8, zero8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic start16 = 0, bin16 = 0, busy16, done16, bout16, zero16;
  logic [15:0] a16 = 0, b16 = 0, diff16;
  int cmp = 0, errs = 0;
  logic [9:0] q8[$];
  logic [17:0] q16[$];
  logic [9:0] e8;
  logic [17:0] e16;
  logic pd8 = 0, pd16 = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8));
  serial_sub_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .zero(zero16));

  function automatic logic [9:0] m8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] f;
    f = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    return {f[7:0], f[8], f[7:0] == 8'd0};
  endfunction

  function automatic logic [17:0] m16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] f;
    f = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    return {f[15:0], f[16], f[15:0] == 16'd0};
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      cmp++;
      if (q8.size() == 0) begin
        errs++;
        $display("FAIL done8_unexpected: got diff=%h bout=%b zero=%b, no op pending", diff8, bout8, zero8);
      end else begin
        e8 = q8.pop_front();
        if ({diff8, bout8, zero8} !== e8) begin
          errs++;
          $display("FAIL result8: got diff=%h bout=%b zero=%b, want diff=%h bout=%b zero=%b",
                   diff8, bout8, zero8, e8[9:2], e8[1], e8[0]);
        end
      end
      if (pd8) begin
        cmp++; errs++;
        $display("FAIL done8_width: got done high 2+ cycles, want 1");
      end
    end
    if (done16) begin
      cmp++;
      if (q16.size() == 0) begin
        errs++;
        $display("FAIL done16_unexpected: got diff=%h, no op pending", diff16);
      end else begin
        e16 = q16.pop_front();
        if ({diff16, bout16, zero16} !== e16) begin
          errs++;
          $display("FAIL result16: got diff=%h bout=%b zero=%b, want diff=%h bout=%b zero=%b",
                   diff16, bout16, zero16, e16[17:2], e16[1], e16[0]);
        end
      end
      if (pd16) begin
        cmp++; errs++;
        $display("FAIL done16_width: got done high 2+ cycles, want 1");
      end
    end
    pd8 = done8;
    pd16 = done16;
  end

  task automatic wait_idle8();
    int t = 0;
    @(negedge clk);
    while (busy8 && t < 100) begin @(negedge clk); t++; end
    if (busy8) begin cmp++; errs++; $display("FAIL idle8_timeout: got busy=1, want 0"); end
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    wait_idle8();
    a8 = a; b8 = b; bin8 = bin; start8 = 1;
    q8.push_back(m8(a, b, bin));
    @(negedge clk);
    start8 = 0;
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int t = 0;
    @(negedge clk);
    while (busy16 && t < 100) begin @(negedge clk); t++; end
    if (busy16) begin cmp++; errs++; $display("FAIL idle16_timeout: got busy=1, want 0"); end
    a16 = a; b16 = b; bin16 = bin; start16 = 1;
    q16.push_back(m16(a, b, bin));
    @(negedge clk);
    start16 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q8.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    cmp++;
    if (q8.size() != 0 || q16.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: got %0d/%0d ops pending, want 0/0", q8.size(), q16.size());
      q8.delete(); q16.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    cmp++;
    if ({busy8, done8, diff8, bout8, zero8} !== 12'd0) begin
      errs++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b zero=%b, want all 0", busy8, done8, diff8, bout8, zero8);
    end
    cmp++;
    if ({busy16, done16, diff16, bout16, zero16} !== 20'd0) begin
      errs++;
      $display("FAIL reset16: got busy=%b done=%b diff=%h, want all 0", busy16, done16, diff16);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    int n = 0;
    wait_idle8();
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 0; start8 = 1;
    q8.push_back(m8(8'h5A, 8'h3C, 1'b0));
    do begin
      @(negedge clk); n++;
      if (n == 1) start8 = 0;
    end while (!done8 && n < 50);
    cmp++;
    if (n !== 9) begin errs++; $display("FAIL latency: got done after %0d negedges, want 9", n); end
    @(negedge clk);
    cmp++;
    if (done8 !== 0 || busy8 !== 0) begin
      errs++;
      $display("FAIL after_done: got done=%b busy=%b, want 0 0", done8, busy8);
    end
    drain();
  endtask

  task automatic test_boundaries();
    go8(8'h00, 8'h01, 1'b0);
    go8(8'h10, 8'h10, 1'b1);
    go8(8'h77, 8'h77, 1'b0);
    go8(8'hFF, 8'h00, 1'b1);
    go8(8'h00, 8'hFF, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int n = 0, idle = 0, dn = 0;
    wait_idle8();
    a8 = 8'h80; b8 = 8'h01; bin8 = 0; start8 = 1;
    q8.push_back(m8(8'h80, 8'h01, 1'b0));
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        a8 = 8'hFF; b8 = 8'hFF;
        q8.push_back(m8(8'hFF, 8'hFF, 1'b0));
      end
      if (!busy8) idle++;
      if (done8) dn++;
    end while (dn < 2 && n < 60);
    start8 = 0;
    cmp++;
    if (idle !== 1) begin errs++; $display("FAIL b2b_idle: got %0d idle cycles, want 1", idle); end
    cmp++;
    if (n !== 19) begin errs++; $display("FAIL b2b_second_done: got at negedge %0d, want 19", n); end
    drain();
  endtask

  task automatic test_reset_abort();
    go8(8'h5A, 8'h3C, 1'b0);
    drain();
    wait_idle8();
    a8 = 8'hC3; b8 = 8'h42; bin8 = 0; start8 = 1;
    @(negedge clk); start8 = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    cmp++;
    if ({busy8, done8, diff8, bout8, zero8} !== 12'd0) begin
      errs++;
      $display("FAIL async_abort: got busy=%b done=%b diff=%h bout=%b zero=%b, want all 0", busy8, done8, diff8, bout8, zero8);
    end
    @(negedge clk);
    rst = 0;
    repeat (15) @(negedge clk);
    go8(8'hC3, 8'h42, 1'b0);
    drain();
  endtask

  task automatic test_input_changes();
    wait_idle8();
    a8 = 8'h25; b8 = 8'h13; bin8 = 1; start8 = 1;
    q8.push_back(m8(8'h25, 8'h13, 1'b1));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start8 = 0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) go8(8'($urandom), 8'($urandom), 1'($urandom));
    drain();
    for (int i = 0; i < 1000; i++) go16(16'($urandom), 16'($urandom), 1'($urandom));
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_input_changes();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
